hazard_scoreboard: RTL

//  Parametrised hazard/forwarding scoreboard for the pipelined core; replaces fixed 3-stage Hazard logic.

---
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destinations, drives ID forward selects, load-use stall and perf counters.
// Build macro ZERO_REG_EN: register 0 is hardwired zero and never forwards or stalls.
module hazard_scoreboard #(
  parameter int REG_AW    = 3,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16,
  localparam int SELW     = $clog2(FWD_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_regwr,
  input  logic              id_memrd,
  input  logic              flush,
  output logic [SELW-1:0]   fwd_a,
  output logic [SELW-1:0]   fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  logic [FWD_DEPTH-1:0] v_reg;
  logic [FWD_DEPTH-1:0] regwr_reg;
  logic [FWD_DEPTH-1:0] memrd_reg;
  logic [REG_AW-1:0]    rw_reg [FWD_DEPTH];

  logic [FWD_DEPTH-1:0] match_a;
  logic [FWD_DEPTH-1:0] match_b;
  logic [FWD_DEPTH-1:0] ld_hit;

  logic              ins_v_next;
  logic [REG_AW-1:0] ins_rw_next;
  logic              ins_regwr_next;
  logic              ins_memrd_next;

  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] fwd_cnt_reg;

  for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_match
    logic live;
`ifdef ZERO_REG_EN
    assign live = v_reg[gi] & regwr_reg[gi] & (rw_reg[gi] != '0);
`else
    assign live = v_reg[gi] & regwr_reg[gi];
`endif
    assign match_a[gi] = live & (rw_reg[gi] == id_rs) & id_rs_used;
    assign match_b[gi] = live & (rw_reg[gi] == id_rt) & id_rt_used;
    // Only the first LOAD_LAT entries hold loads whose data is not yet available.
    assign ld_hit[gi]  = (gi < LOAD_LAT) & memrd_reg[gi] & (match_a[gi] | match_b[gi]);
  end

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (match_a[i]) fwd_a = SELW'(i + 1);
      if (match_b[i]) fwd_b = SELW'(i + 1);
    end
  end

  assign stall = id_valid & ~flush & (|ld_hit);

  always_comb begin
    ins_v_next     = id_valid & ~stall & ~flush;
    ins_rw_next    = '0;
    ins_regwr_next = 1'b0;
    ins_memrd_next = 1'b0;
    if (ins_v_next) begin
      ins_rw_next    = id_rw;
      ins_regwr_next = id_regwr;
      ins_memrd_next = id_memrd;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v_reg     <= '0;
      regwr_reg <= '0;
      memrd_reg <= '0;
      for (int i = 0; i < FWD_DEPTH; i++) rw_reg[i] <= '0;
    end else begin
      for (int i = FWD_DEPTH - 1; i > 0; i--) begin
        v_reg[i]     <= v_reg[i-1];
        regwr_reg[i] <= regwr_reg[i-1];
        memrd_reg[i] <= memrd_reg[i-1];
        rw_reg[i]    <= rw_reg[i-1];
      end
      v_reg[0]     <= ins_v_next;
      regwr_reg[0] <= ins_regwr_next;
      memrd_reg[0] <= ins_memrd_next;
      rw_reg[0]    <= ins_rw_next;
    end
  end

  // Saturating counters: hold at all-ones rather than wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_reg <= '0;
      fwd_cnt_reg   <= '0;
    end else begin
      if (stall && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (((fwd_a != '0) || (fwd_b != '0)) && (fwd_cnt_reg != '1))
        fwd_cnt_reg <= fwd_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign fwd_cnt   = fwd_cnt_reg;

endmodule
